// File: rtl/multi_ch_out_buffer.sv
// N-channel circular output FIFO bank drained by an Avalon-MM style slave, fixed 2-cycle read latency.
// Optional irq output and threshold logic are built only when OUT_BUF_IRQ_EN is defined.
module multi_ch_out_buffer #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 12,
  parameter int IRQ_THRESH = 2**ADDR_W - 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        wr_en,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic                     chipselect,
  input  logic                     read,
  input  logic                     write,
  input  logic [3:0]               address,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic                     readdatavalid
`ifdef OUT_BUF_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int PW    = ADDR_W + 1;

  logic [PW-1:0]            r_wr_ptr [NUM_CH];
  logic [PW-1:0]            r_rd_ptr [NUM_CH];
  logic [PW-1:0]            w_count  [NUM_CH];
  logic [NUM_CH-1:0]        w_empty, w_full, w_flush;
  logic [NUM_CH-1:0]        w_push_ok, w_pop_ok, w_ovf_set, w_unf_set;
  logic [NUM_CH-1:0]        r_ovf, r_unf;
  logic                     w_rd_acc, w_ctrl_wr, w_clr;
  logic [NUM_CH*DATA_W-1:0] w_q_all;
  logic [31:0]              w_status, w_p1_const, w_q_sel;
  logic                     w_p1_is_pop;
  logic                     r_p1_valid, r_p1_is_pop;
  logic [2:0]               r_p1_ch;
  logic [31:0]              r_p1_const;
  logic                     w_unused;

  assign w_unused = ^writedata;

  // Full/empty and all same-cycle arbitration use the pre-cycle pointers.
  always_comb begin
    w_rd_acc  = chipselect && read;
    w_ctrl_wr = chipselect && write && (address == 4'hF);
    w_clr     = w_ctrl_wr && writedata[31];
    for (int i = 0; i < NUM_CH; i++) begin
      w_count[i]   = r_wr_ptr[i] - r_rd_ptr[i];
      w_empty[i]   = (w_count[i] == '0);
      w_full[i]    = (w_count[i] == PW'(DEPTH));
      w_flush[i]   = w_ctrl_wr && writedata[i];
      w_pop_ok[i]  = w_rd_acc && (address == 4'(i)) && !w_empty[i] && !w_flush[i];
      w_unf_set[i] = w_rd_acc && (address == 4'(i)) && w_empty[i] && !w_flush[i];
      w_push_ok[i] = wr_en[i] && !w_flush[i] && (!w_full[i] || w_pop_ok[i]);
      w_ovf_set[i] = wr_en[i] && !w_flush[i] && w_full[i] && !w_pop_ok[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
      r_ovf <= '0;
      r_unf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_flush[i]) begin
          r_wr_ptr[i] <= '0;
          r_rd_ptr[i] <= '0;
        end else begin
          if (w_push_ok[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
          if (w_pop_ok[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        end
      end
      r_ovf <= (r_ovf & ~{NUM_CH{w_clr}}) | w_ovf_set;
      r_unf <= (r_unf & ~{NUM_CH{w_clr}}) | w_unf_set;
    end
  end

  // Read-first RAM: a pop of a full channel reads the old word even when the same slot is written.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_W-1:0] r_mem [DEPTH];
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk) begin
        if (w_push_ok[gi]) r_mem[r_wr_ptr[gi][ADDR_W-1:0]] <= wr_data[gi*DATA_W +: DATA_W];
        r_q <= r_mem[r_rd_ptr[gi][ADDR_W-1:0]];
      end
      assign w_q_all[gi*DATA_W +: DATA_W] = r_q;
    end
  endgenerate

  always_comb begin
    w_status = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_status[i]      = w_empty[i];
      w_status[8 + i]  = w_full[i];
      w_status[16 + i] = r_ovf[i];
      w_status[24 + i] = r_unf[i];
    end
    w_p1_is_pop = 1'b0;
    w_p1_const  = 32'h0000_00FF;
    if (address < 4'(NUM_CH)) begin
      w_p1_is_pop = |w_pop_ok;
      w_p1_const  = '0;
    end else if (address == 4'd8) begin
      w_p1_const = w_status;
    end else if (address == 4'hF) begin
      w_p1_const = {16'h0, 8'(ADDR_W), 8'(NUM_CH)};
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (address == 4'(9 + i)) w_p1_const = 32'(w_count[i]);
    end
  end

  always_comb begin
    w_q_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_p1_ch == 3'(i)) w_q_sel = 32'(w_q_all[i*DATA_W +: DATA_W]);
  end

  // Stage 1 runs alongside the RAM read; stage 2 registers readdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p1_valid    <= 1'b0;
      r_p1_is_pop   <= 1'b0;
      r_p1_ch       <= '0;
      r_p1_const    <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      r_p1_valid    <= w_rd_acc;
      r_p1_is_pop   <= w_p1_is_pop;
      r_p1_ch       <= address[2:0];
      r_p1_const    <= w_p1_const;
      readdatavalid <= r_p1_valid;
      if (r_p1_valid) readdata <= r_p1_is_pop ? w_q_sel : r_p1_const;
    end
  end

`ifdef OUT_BUF_IRQ_EN
  logic          r_irq_en, w_irq_en_next, w_irq_next;
  logic [PW-1:0] w_cnt_next [NUM_CH];

  // irq is evaluated on next-state values so it tracks the causing event by exactly one cycle.
  always_comb begin
    w_irq_en_next = w_ctrl_wr ? writedata[30] : r_irq_en;
    w_irq_next    = |((r_ovf & ~{NUM_CH{w_clr}}) | w_ovf_set);
    for (int i = 0; i < NUM_CH; i++) begin
      w_cnt_next[i] = w_flush[i] ? '0 : w_count[i] + PW'(w_push_ok[i]) - PW'(w_pop_ok[i]);
      if (int'(w_cnt_next[i]) >= IRQ_THRESH) w_irq_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      irq      <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_next;
      irq      <= w_irq_en_next && w_irq_next;
    end
  end
`endif

endmodule

// File: tb/tb_multi_ch_out_buffer.sv
// Scoreboard bench for multi_ch_out_buffer: reads push expected words, a negedge monitor pops and checks them.
module tb_multi_ch_out_buffer;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        wr_en = '0;
  logic [NUM_CH*DATA_W-1:0] wr_data = '0;
  logic                     chipselect = 1'b0;
  logic                     read = 1'b0;
  logic                     write = 1'b0;
  logic [3:0]               address = '0;
  logic [31:0]              writedata = '0;
  logic [31:0]              readdata;
  logic                     readdatavalid;
`ifdef OUT_BUF_IRQ_EN
  logic                     irq;
`endif

  multi_ch_out_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid)
`ifdef OUT_BUF_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: every readdatavalid pulse must match the oldest expectation, at its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (readdatavalid) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rdv: readdata=%h with no read outstanding (cyc %0d)", readdata, cyc);
      end else begin
        e = sb.pop_front();
        if (readdata !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: got %h at cyc %0d, expected %h at cyc %0d", e.name, readdata, cyc, e.data, e.due);
        end else begin
          $display("[TB] %s: readdata=%h cyc=%0d ok", e.name, readdata, cyc);
        end
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: no readdatavalid by cyc %0d, expected %h", e.name, cyc, e.data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    wr_en      = '0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] d, input string nm);
    exp_t e;
    step();
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    e.data = d;
    e.due  = cyc + 2;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push1(input int ch, input logic [31:0] d);
    step();
    wr_en[ch] = 1'b1;
    wr_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    step();
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 4'hF;
    writedata  = v;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("[TB] %s: %h ok", nm, act);
    end
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdv", 32'(readdatavalid), 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset = 1'b0;

    rd(4'hF, 32'h0000_0C03, "id");
    rd(4'd8, 32'h0000_0007, "status_after_reset");
    // Read in flight when reset hits: must vanish
    step();
    chipselect = 1'b1; read = 1'b1; address = 4'hF;
    step();
    reset = 1'b1;
    step();
    step();
    chk("reset_clears_readdata", readdata, 32'h0);
    reset = 1'b0;

    // Basic FIFO order on channel 1
    push1(1, 32'd5); push1(1, 32'd6); push1(1, 32'd7);
    rd(4'd1, 32'd5, "ch1_pop0"); rd(4'd1, 32'd6, "ch1_pop1"); rd(4'd1, 32'd7, "ch1_pop2");
    rd(4'd10, 32'd0, "ch1_count_empty");

    // Unmapped addresses
    rd(4'd3, 32'h0000_00FF, "addr3"); rd(4'd5, 32'h0000_00FF, "addr5");
    rd(4'd12, 32'h0000_00FF, "addr12"); rd(4'd14, 32'h0000_00FF, "addr14");

    // Fill channel 0, then overflow it
    for (int i = 0; i < 4096; i++) push1(0, 32'hC000_0000 + i);
    push1(0, 32'h0000_00AA);
    rd(4'd9, 32'd4096, "ch0_count_full");
    rd(4'd8, 32'h0001_0106, "status_full_ovf");
    // Clear together with a fresh overflow: flag stays set
    wr_ctrl(32'h8000_0000);
    wr_en[0] = 1'b1; wr_data[31:0] = 32'h0000_00AB;
    rd(4'd8, 32'h0001_0106, "status_clear_vs_ovf");
    wr_ctrl(32'h8000_0000);
    rd(4'd8, 32'h0000_0106, "status_cleared");
    // Push and pop together while full
    rd(4'd0, 32'hC000_0000, "ch0_pop_push_full");
    wr_en[0] = 1'b1; wr_data[31:0] = 32'h5555_0001;
    rd(4'd9, 32'd4096, "ch0_count_still_full");
    rd(4'd8, 32'h0000_0106, "status_no_ovf");
    for (int i = 1; i < 4096; i++) rd(4'd0, 32'hC000_0000 + i, "ch0_drain");
    rd(4'd0, 32'h5555_0001, "ch0_drain_last");
    rd(4'd9, 32'd0, "ch0_count_drained");
    rd(4'd8, 32'h0000_0007, "status_drained");
    // Refill across the RAM index wrap
    push1(0, 32'h1111); push1(0, 32'h2222); push1(0, 32'h3333);
    rd(4'd9, 32'd3, "ch0_count_wrap");
    rd(4'd0, 32'h1111, "ch0_wrap0"); rd(4'd0, 32'h2222, "ch0_wrap1"); rd(4'd0, 32'h3333, "ch0_wrap2");
    rd(4'd9, 32'd0, "ch0_count_wrap_empty");

    // Underflow on channel 2, then clear
    rd(4'd2, 32'h0, "ch2_underflow");
    rd(4'd8, 32'h0400_0007, "status_unf");
    wr_ctrl(32'h8000_0000);
    rd(4'd8, 32'h0000_0007, "status_unf_cleared");
    // Pop while empty with a same-cycle push
    rd(4'd2, 32'h0, "ch2_pop_empty_push");
    wr_en[2] = 1'b1; wr_data[95:64] = 32'h77;
    rd(4'd11, 32'd1, "ch2_count_after_push");
    rd(4'd8, 32'h0400_0003, "status_unf_push");
    rd(4'd2, 32'h77, "ch2_pop_pushed");
    rd(4'd8, 32'h0400_0007, "status_ch2_empty");
    wr_ctrl(32'h8000_0000);

    // Flush with a same-cycle push on channel 1
    push1(1, 32'h10); push1(1, 32'h11);
    rd(4'd10, 32'd2, "ch1_count_pre_flush");
    wr_ctrl(32'h0000_0002);
    wr_en[1] = 1'b1; wr_data[63:32] = 32'h12;
    rd(4'd10, 32'd0, "ch1_count_flushed");
    rd(4'd8, 32'h0000_0007, "status_after_flush");

`ifdef OUT_BUF_IRQ_EN
    wr_ctrl(32'h4000_0000);
    for (int i = 0; i < 4079; i++) push1(0, i);
    step();
    chk("irq_below_thresh", 32'(irq), 32'h0);
    push1(0, 32'd4079);
    step();
    chk("irq_at_thresh", 32'(irq), 32'h1);
    rd(4'd0, 32'd0, "irq_pop");
    step();
    chk("irq_after_pop", 32'(irq), 32'h0);
    wr_ctrl(32'h0000_0001);
`endif

    step();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d reads outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_ch_out_buffer.md
Name: multi_ch_out_buffer

Overview:
Parametrised N-channel output buffer that collects result words from compute lanes into per-channel circular FIFOs built on simple dual-port synchronous RAM. A host drains the FIFOs through an Avalon-MM style slave port. Compared with the fixed 3-channel buffer it adds:
- true FIFO full/empty tracking with wrap-around,
- sticky overflow/underflow flags,
- per-channel occupancy readback and flush,
- a fixed 2-cycle read latency with readdatavalid, in place of a two-access read.

Parameters:
NUM_CH, 3, number of channels; legal range 1..6.
DATA_W, 32, width of each channel word; legal range 1..32; zero-extended onto readdata.
ADDR_W, 12, log2 of per-channel depth; DEPTH = 2**ADDR_W.
IRQ_THRESH, 2**ADDR_W-16, occupancy level that raises irq (used only with OUT_BUF_IRQ_EN).

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  NUM_CH  per-channel push strobe, bit i = channel i
wr_data  in  NUM_CH*DATA_W  channel i data in bits [i*DATA_W +: DATA_W]
chipselect  in  1  slave select
read  in  1  slave read strobe
write  in  1  slave write strobe
address  in  4  slave word address
writedata  in  32  slave write data
readdata  out  32  slave read data
readdatavalid  out  1  one-cycle pulse marking valid readdata
irq  out  1  present only with OUT_BUF_IRQ_EN

Behaviour:
- Reset (synchronous, active-high):
  - All read/write pointers, sticky flags and the irq-enable bit go to 0.
  - readdata = 0, readdatavalid = 0, irq = 0.
  - A read in flight is discarded and no readdatavalid is issued.
- Per-channel state: wr_ptr and rd_ptr, each ADDR_W+1 bits.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_W+1).
  - empty when count == 0; full when count == DEPTH.
  - RAM is indexed by ptr[ADDR_W-1:0], so addresses wrap naturally.
- Push on channel i (wr_en[i]=1):
  - Not full: write wr_data to RAM[wr_ptr]; wr_ptr increments.
  - Full: word is dropped and ovf[i] is set (sticky).
- Host read is accepted when chipselect && read. One access per cycle; back-to-back reads are allowed.
- Pop, address 0..NUM_CH-1:
  - Not empty: RAM read at rd_ptr in the accept cycle T; rd_ptr increments at the end of T.
  - readdata is registered from RAM q, so readdata and readdatavalid appear at T+2.
  - Empty: no pointer change, unf[i] is set (sticky), readdata = 0 at T+2 with readdatavalid.
- Status, address 8: bit i = empty[i], bit 8+i = full[i], bit 16+i = ovf[i], bit 24+i = unf[i]. Returned at T+2.
- Count, address 9+i (i < NUM_CH): count of channel i, zero-extended. Returned at T+2.
- ID, address 15 read: {16'h0, ADDR_W[7:0], NUM_CH[7:0]}.
- Any other read address returns 32'h0000_00FF at T+2.
- Every accepted read yields exactly one readdatavalid pulse, in order.
- Control, address 15 write (chipselect && write):
  - writedata bit i = flush channel i (wr_ptr = rd_ptr = 0).
  - bit 31 = clear all ovf/unf flags.
  - bit 30 = irq enable.
  - Writes to other addresses are ignored.
- Simultaneous events on the same channel in one cycle:
  - Push and pop: both take effect and count is unchanged.
  - Push while full with a pop: push is accepted (full is evaluated on pre-cycle count minus the pop) and no ovf is raised.
  - Pop while empty with a push: pop is an underflow (pre-cycle count), the push is accepted, readdata = 0.
  - Flush with push or pop: flush wins; the push is discarded without setting ovf, and the pop returns 0 without setting unf.
  - Clear-flags with a new ovf/unf event: the new event wins and the flag stays set.
- Occupancy is the only flow control; pops observe pushes completed in earlier cycles.

Optional Feature:
- Macro: OUT_BUF_IRQ_EN.
- Defined:
  - irq port exists and is registered.
  - irq = enable bit && (any channel count >= IRQ_THRESH || any ovf flag set).
  - irq updates 1 cycle after the causing event.
- Undefined:
  - No irq port and no threshold compare logic.
  - Control bit 30 is ignored.

Test Plan:
- Reset, then read address 15 -> readdata 32'h0000_0C03 with readdatavalid 2 cycles after accept; address 8 -> 32'h0000_0007 (all empty).
- Push 5, 6, 7 on channel 1, then pop address 1 three times back-to-back -> readdata 5, 6, 7 on consecutive cycles T+2..T+4; then address 10 -> 0.
- Fill channel 0 with 4096 words, then push 0xAA -> address 9 returns 4096, status bit 8 = 1, bit 16 = 1; popping 4096 returns words in order and 0xAA never appears; the pointer wrap is exercised on a refill.
- Pop empty channel 2 -> readdata 0, status bit 26 = 1; write address 15 with 32'h8000_0000 -> status bits 16..29 = 0.
- Channel 0 full, with push and pop in the same cycle -> count stays 4096 and ovf stays 0; flush plus push on channel 1 in one cycle -> count 0 and ovf stays 0.
- OUT_BUF_IRQ_EN: write 32'h4000_0000, then push 4080 words on channel 0 -> irq rises 1 cycle after the 4080th push; one pop makes irq fall.
